// File: rtl/keypad_pkg.sv
// Shared types and board constants for the hex keypad entry block.
// The keypad layout lives only in KEY_MAP, indexed by {row, col}.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Board layout: row 0 = 1 2 3 A, row 1 = 4 5 6 B, row 2 = 7 8 9 C, row 3 = 0 F E D
    localparam logic [0:15][3:0] KEY_MAP = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan tick generator: free-running divider, tick is high for the one clk
// in which the counter is all-ones, so state acts on the wrap to zero.
module keypad_tick_gen #(
    parameter int SCAN_DIV_BITS = 17
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [SCAN_DIV_BITS-1:0] div_cnt;

    // Free-running divider, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_cnt <= '0;
        else     div_cnt <= div_cnt + SCAN_DIV_BITS'(1);
    end

    assign tick = &div_cnt;

endmodule

// File: rtl/keypad_hex_entry.sv
// 4x4 hex keypad scanner with debounce and a shifting entry register.
// Optional build macro KEYPAD_REPEAT_EN enables auto-repeat while a key is held.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SCAN     | strobing columns, advance one column per tick while idle
// DEBOUNCE | row seen low, counting identical ticks before acceptance
// HELD     | key accepted, waiting for a stable release
module keypad_hex_entry
    import keypad_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SCAN_DIV_BITS  = 17,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_ROWS-1:0]        row_n,
    input  logic                       entry_clr,
    output logic [NUM_COLS-1:0]        col_n,
    output logic                       key_valid,
    output logic [3:0]                 key_code,
    output logic [WIDTH-1:0]           value,
    output logic [$clog2(WIDTH/4):0]   digit_cnt
);

    localparam int DIG_W = $clog2(WIDTH/4) + 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    // Elaboration-time parameter sanity
    if (WIDTH % 4 != 0 || WIDTH < 8) begin : g_bad_width
        $error("keypad_hex_entry: WIDTH must be a multiple of 4 and at least 8");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_deb
        $error("keypad_hex_entry: DEBOUNCE_SCANS must be at least 1");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_rep
        $error("keypad_hex_entry: REPEAT_SCANS must be at least 1");
    end

    logic                tick;
    logic [NUM_ROWS-1:0] row_meta, row_sync;
    logic                any_low;
    logic [1:0]          low_idx;

    kp_state_t           state, state_next;
    logic [1:0]          col_idx, row_lat, row_lat_next;
    logic [CNT_W-1:0]    deb_cnt, deb_next, rel_cnt, rel_next;
    logic                advance, accept, rep_fire, shift;
    logic [3:0]          new_code;

    keypad_tick_gen #(.SCAN_DIV_BITS(SCAN_DIV_BITS)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer; idle keypad reads all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    assign any_low  = ~&row_sync;
    assign new_code = KEY_MAP[{row_lat, col_idx}];
    assign shift    = accept | rep_fire;

    // Lowest-index low row wins when several rows are low
    always_comb begin
        low_idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!row_sync[i]) low_idx = 2'(i);
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    logic [REP_W-1:0] rep_cnt, rep_next;

    // Auto-repeat counter: counts held ticks, restarts on entry to HELD or key up
    always_comb begin
        rep_next = rep_cnt;
        rep_fire = 1'b0;
        if (tick) begin
            if (state != HELD || !any_low) begin
                rep_next = '0;
            end else if (rep_cnt + REP_W'(1) == REP_W'(REPEAT_SCANS)) begin
                rep_next = '0;
                rep_fire = 1'b1;
            end else begin
                rep_next = rep_cnt + REP_W'(1);
            end
        end
    end

    // Auto-repeat counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_cnt <= '0;
        else     rep_cnt <= rep_next;
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Next-state and counter decisions, evaluated only on tick
    always_comb begin
        state_next   = state;
        row_lat_next = row_lat;
        deb_next     = deb_cnt;
        rel_next     = rel_cnt;
        advance      = 1'b0;
        accept       = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        row_lat_next = low_idx;
                        deb_next     = CNT_W'(1);
                        state_next   = DEBOUNCE;
                    end else begin
                        advance = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (any_low && low_idx == row_lat) begin
                        if (deb_cnt >= CNT_W'(DEBOUNCE_SCANS)) begin
                            accept     = 1'b1;
                            rel_next   = '0;
                            state_next = HELD;
                        end else begin
                            deb_next = deb_cnt + CNT_W'(1);
                        end
                    end else begin
                        advance    = 1'b1;
                        state_next = SCAN;
                    end
                end
                HELD: begin
                    if (any_low) begin
                        rel_next = '0;
                    end else if (rel_cnt + CNT_W'(1) == CNT_W'(DEBOUNCE_SCANS)) begin
                        rel_next   = '0;
                        advance    = 1'b1;
                        state_next = SCAN;
                    end else begin
                        rel_next = rel_cnt + CNT_W'(1);
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

    // FSM, column strobe and key output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            col_n     <= 4'b1110;
            row_lat   <= 2'd0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            state     <= state_next;
            row_lat   <= row_lat_next;
            deb_cnt   <= deb_next;
            rel_cnt   <= rel_next;
            key_valid <= shift;
            if (shift) key_code <= new_code;
            if (advance) begin
                col_idx <= col_idx + 2'd1;
                col_n   <= ~(4'b0001 << (col_idx + 2'd1));
            end
        end
    end

    // Entry register: clear beats a simultaneous key, oldest nibble falls off the top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value     <= '0;
            digit_cnt <= '0;
        end else if (entry_clr) begin
            value     <= '0;
            digit_cnt <= '0;
        end else if (shift) begin
            value <= {value[WIDTH-5:0], new_code};
            if (digit_cnt != DIG_W'(WIDTH/4)) digit_cnt <= digit_cnt + DIG_W'(1);
        end
    end

endmodule
